// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch driven by a 1 Hz square-wave time base.
// The divider output is rising-edge detected in the clk domain; start_stop
// toggles run/pause, clear either clears (when stopped) or toggles a lap freeze
// (when running). The displayed digits are the live count or the frozen lap value.
module stopwatch_core #(
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec_clk,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] disp_m10,
   output logic [3:0] disp_m1,
   output logic [3:0] disp_s10,
   output logic [3:0] disp_s1,
   output logic       running,
   output logic       lap_active,
   output logic       wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Minute limit split into BCD digits once at elaboration.
   localparam logic [3:0] MAX_M10 = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_M1  = 4'(MAX_MIN % 10);

   state_t     state_r;
   logic       sec_d_r;
   logic       lap_active_r;
   logic       wrap_r;

   logic [3:0] live_m10_r, live_m1_r, live_s10_r, live_s1_r;
   logic [3:0] lap_m10_r,  lap_m1_r,  lap_s10_r,  lap_s1_r;

   logic [3:0] nxt_m10_s, nxt_m1_s, nxt_s10_s, nxt_s1_s;
   logic       at_max_s;
   logic       tick_s;
   logic       inc_s;

   // One-cycle tick on each rising edge of the seconds time base.
   assign tick_s = sec_clk & ~sec_d_r;

   // Counting is gated by the registered state, so a start_stop arriving with
   // a tick in RUN still lets that tick count before pausing.
   assign inc_s = (state_r == RUN) & tick_s;

   // BCD successor of the live count, including rollover at MAX_MIN:59.
   always_comb begin
      nxt_m10_s = live_m10_r;
      nxt_m1_s  = live_m1_r;
      nxt_s10_s = live_s10_r;
      nxt_s1_s  = live_s1_r;
      at_max_s  = (live_m10_r == MAX_M10) && (live_m1_r == MAX_M1) &&
                  (live_s10_r == 4'd5)    && (live_s1_r == 4'd9);
      if (live_s1_r == 4'd9) begin
         nxt_s1_s = 4'd0;
         if (live_s10_r == 4'd5) begin
            nxt_s10_s = 4'd0;
            if (at_max_s) begin
               nxt_m10_s = 4'd0;
               nxt_m1_s  = 4'd0;
            end else if (live_m1_r == 4'd9) begin
               nxt_m1_s  = 4'd0;
               nxt_m10_s = live_m10_r + 4'd1;
            end else begin
               nxt_m1_s  = live_m1_r + 4'd1;
            end
         end else begin
            nxt_s10_s = live_s10_r + 4'd1;
         end
      end else begin
         nxt_s1_s = live_s1_r + 4'd1;
      end
   end

   // Control FSM, live/lap counters, edge-detect register and wrap pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         sec_d_r      <= sec_clk;
         lap_active_r <= 1'b0;
         wrap_r       <= 1'b0;
         live_m10_r   <= 4'd0;
         live_m1_r    <= 4'd0;
         live_s10_r   <= 4'd0;
         live_s1_r    <= 4'd0;
         lap_m10_r    <= 4'd0;
         lap_m1_r     <= 4'd0;
         lap_s10_r    <= 4'd0;
         lap_s1_r     <= 4'd0;
      end else begin
         sec_d_r <= sec_clk;
         wrap_r  <= 1'b0;

         if (inc_s) begin
            live_m10_r <= nxt_m10_s;
            live_m1_r  <= nxt_m1_s;
            live_s10_r <= nxt_s10_s;
            live_s1_r  <= nxt_s1_s;
            wrap_r     <= at_max_s;
         end

         case (state_r)
            IDLE: begin
               // clear in IDLE has nothing to do: counters are already zero.
               if (start_stop) begin
                  state_r <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (start_stop) begin
                  state_r <= PAUSE;
               end else if (clear) begin
                  state_r      <= RUN;
                  lap_active_r <= ~lap_active_r;
                  // Freeze the value shown before this cycle's increment.
                  if (!lap_active_r) begin
                     lap_m10_r <= live_m10_r;
                     lap_m1_r  <= live_m1_r;
                     lap_s10_r <= live_s10_r;
                     lap_s1_r  <= live_s1_r;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            PAUSE: begin
               if (start_stop) begin
                  state_r <= RUN;
               end else if (clear) begin
                  state_r      <= IDLE;
                  lap_active_r <= 1'b0;
                  live_m10_r   <= 4'd0;
                  live_m1_r    <= 4'd0;
                  live_s10_r   <= 4'd0;
                  live_s1_r    <= 4'd0;
                  lap_m10_r    <= 4'd0;
                  lap_m1_r     <= 4'd0;
                  lap_s10_r    <= 4'd0;
                  lap_s1_r     <= 4'd0;
               end else begin
                  state_r <= PAUSE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Display source select: frozen lap value or live count, no added latency.
   always_comb begin
      if (lap_active_r) begin
         disp_m10 = lap_m10_r;
         disp_m1  = lap_m1_r;
         disp_s10 = lap_s10_r;
         disp_s1  = lap_s1_r;
      end else begin
         disp_m10 = live_m10_r;
         disp_m1  = live_m1_r;
         disp_s10 = live_s10_r;
         disp_s1  = live_s1_r;
      end
   end

   assign running    = (state_r == RUN);
   assign lap_active = lap_active_r;
   assign wrap       = wrap_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed stimulus with a scoreboard queue of expected
// display/status values; a monitor pops and compares on each check strobe.
module tb_stopwatch_core;

   logic       clk;
   logic       rst;
   logic       sec_clk;
   logic       start_stop;
   logic       clear;
   logic [3:0] disp_m10, disp_m1, disp_s10, disp_s1;
   logic       running;
   logic       lap_active;
   logic       wrap;

   stopwatch_core #(.MAX_MIN(59)) dut (
      .clk        (clk),
      .rst        (rst),
      .sec_clk    (sec_clk),
      .start_stop (start_stop),
      .clear      (clear),
      .disp_m10   (disp_m10),
      .disp_m1    (disp_m1),
      .disp_s10   (disp_s10),
      .disp_s1    (disp_s1),
      .running    (running),
      .lap_active (lap_active),
      .wrap       (wrap)
   );

   typedef struct packed {
      logic [15:0] disp;
      logic        run;
      logic        lap;
      logic        wr;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   logic  chk_req;
   int    checks;
   int    failures;
   int    wrap_cnt;
   int    live_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Count every cycle the wrap pulse is high.
   always @(negedge clk) begin
      if (wrap === 1'b1) wrap_cnt = wrap_cnt + 1;
   end

   // Scoreboard monitor: compare DUT outputs with the next queued expectation.
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      if (chk_req) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard: check strobe with empty expectation queue");
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if ({disp_m10, disp_m1, disp_s10, disp_s1} !== e.disp ||
                running !== e.run || lap_active !== e.lap || wrap !== e.wr) begin
               failures = failures + 1;
               $display("FAIL %s: got disp=%h run=%b lap=%b wrap=%b, expected disp=%h run=%b lap=%b wrap=%b",
                        nm, {disp_m10, disp_m1, disp_s10, disp_s1}, running, lap_active, wrap,
                        e.disp, e.run, e.lap, e.wr);
            end
         end
      end
   end

   function automatic logic [15:0] to_bcd(input int n);
      int t, m, s;
      t = n % 3600;
      m = t / 60;
      s = t % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string nm, input logic [15:0] d,
                             input logic r, input logic l, input logic w);
      exp_t e;
      e.disp = d; e.run = r; e.lap = l; e.wr = w;
      exp_q.push_back(e);
      name_q.push_back(nm);
      chk_req = 1'b1;
      step();
      chk_req = 1'b0;
   endtask

   task automatic pulse(input logic ss, input logic cl);
      start_stop = ss;
      clear      = cl;
      step();
      start_stop = 1'b0;
      clear      = 1'b0;
   endtask

   // One seconds edge; the expectation is checked in the cycle after the update.
   task automatic do_tick(input string nm, input logic [15:0] d,
                          input logic r, input logic l, input logic w);
      sec_clk = 1'b1;
      step();
      sec_clk = 1'b0;
      expect_now(nm, d, r, l, w);
   endtask

   // Running tick checked against the seconds-count model.
   task automatic run_tick(input string nm);
      live_n = live_n + 1;
      do_tick(nm, to_bcd(live_n), 1'b1, 1'b0, (live_n % 3600) == 0);
   endtask

   initial begin
      checks = 0; failures = 0; wrap_cnt = 0; live_n = 0;
      chk_req = 1'b0; rst = 1'b1; sec_clk = 1'b1; start_stop = 1'b0; clear = 1'b0;

      // Reset with sec_clk held high, then release.
      repeat (3) step();
      rst = 1'b0;
      repeat (3) step();
      expect_now("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);
      expect_now("idle_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      expect_now("start_no_tick", 16'h0000, 1'b1, 1'b0, 1'b0);
      sec_clk = 1'b0;
      step();

      // 75 seconds.
      for (int i = 0; i < 75; i++) run_tick("count");
      expect_now("disp_0115", 16'h0115, 1'b1, 1'b0, 1'b0);

      // Through 58:59, over the 59:59 wrap, on to 00:59.
      while (live_n < 3539) run_tick("run_long");
      expect_now("disp_5859", 16'h5859, 1'b1, 1'b0, 1'b0);
      while (live_n < 3659) run_tick("run_wrap");
      expect_now("disp_0059", 16'h0059, 1'b1, 1'b0, 1'b0);
      checks = checks + 1;
      if (wrap_cnt != 1) begin
         failures = failures + 1;
         $display("FAIL wrap_count: got %0d, expected 1", wrap_cnt);
      end

      // Pause, clear back to IDLE, restart.
      pulse(1'b1, 1'b0);
      expect_now("pause_0059", 16'h0059, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);
      expect_now("pause_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      expect_now("restart", 16'h0000, 1'b1, 1'b0, 1'b0);
      live_n = 0;

      // Lap freeze at 00:10 while 5 more seconds pass.
      for (int i = 0; i < 10; i++) run_tick("lap_pre");
      pulse(1'b0, 1'b1);
      expect_now("lap_on", 16'h0010, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         live_n = live_n + 1;
         do_tick("lap_hold", 16'h0010, 1'b1, 1'b1, 1'b0);
      end
      pulse(1'b0, 1'b1);
      expect_now("lap_off", 16'h0015, 1'b1, 1'b0, 1'b0);

      // start_stop coincident with a tick at 00:20.
      for (int i = 0; i < 5; i++) run_tick("to_0020");
      sec_clk = 1'b1; start_stop = 1'b1;
      step();
      sec_clk = 1'b0; start_stop = 1'b0;
      live_n = live_n + 1;
      expect_now("tick_and_stop", 16'h0021, 1'b0, 1'b0, 1'b0);
      do_tick("pause_tick", 16'h0021, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b1);
      expect_now("stop_and_clear", 16'h0021, 1'b1, 1'b0, 1'b0);

      // Pause at 03:07, clear to IDLE.
      while (live_n < 187) run_tick("to_0307");
      pulse(1'b1, 1'b0);
      expect_now("pause_0307", 16'h0307, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);
      expect_now("clear_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

      // Reset mid-RUN with lap active and a tick pending.
      pulse(1'b1, 1'b0);
      live_n = 0;
      for (int i = 0; i < 3; i++) run_tick("pre_rst");
      pulse(1'b0, 1'b1);
      expect_now("lap_pre_rst", 16'h0003, 1'b1, 1'b1, 1'b0);
      sec_clk = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      expect_now("rst_mid_run", 16'h0000, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      expect_now("post_rst_start", 16'h0000, 1'b1, 1'b0, 1'b0);
      sec_clk = 1'b0;
      step();

      checks = checks + 1;
      if (exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
      end
      checks = checks + 1;
      if (wrap_cnt != 1) begin
         failures = failures + 1;
         $display("FAIL wrap_total: got %0d, expected 1", wrap_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
